// File: rtl/div_seq_ctrl.sv
// Iterative divider for the RV32IM EX stage: DIV/DIVU/REM/REMU.
// Restoring algorithm, one quotient bit per cycle. A fast path handles
// divide-by-zero and signed overflow, and a FIX cycle applies the signs.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       FUNCT3,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    input  logic             FLUSH,
    output logic             STALL,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic             op_rem, q_neg, r_neg;

    logic             in_signed, in_rem, a_neg, b_neg, div0, ovf, fast;
    logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
    logic [WIDTH:0]   trial;

    // Operand decode, fast-path detection and the shared subtract/shift datapath
    always_comb begin
        in_signed = (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
        in_rem    = (FUNCT3 == 3'b110) || (FUNCT3 == 3'b111);
        a_neg     = in_signed & DIVIDEND[WIDTH-1];
        b_neg     = in_signed & DIVISOR[WIDTH-1];
        mag_a     = a_neg ? -DIVIDEND : DIVIDEND;
        mag_b     = b_neg ? -DIVISOR : DIVISOR;
        div0      = (DIVISOR == '0);
        ovf       = in_signed && (DIVIDEND == MIN_NEG) && (DIVISOR == '1);
        fast      = div0 || ovf;
        // The shifted partial remainder can exceed WIDTH bits, hence WIDTH+1
        trial     = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
        q_fix     = q_neg ? -quo : quo;
        r_fix     = r_neg ? -rem : rem;
    end

    // Next-state logic; FLUSH aborts from any state and beats START
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = fast ? S_DONE : S_CALC;
            S_CALC:  if (cnt == CNT_LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (FLUSH) state_nxt = S_IDLE;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Datapath registers; a flush leaves everything, including RESULT, untouched
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            op_rem <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            RESULT <= '0;
        end else if (!FLUSH) begin
            case (state)
                S_IDLE: if (START) begin
                    cnt    <= '0;
                    rem    <= '0;
                    quo    <= mag_a;
                    dvsr   <= mag_b;
                    op_rem <= in_rem;
                    q_neg  <= a_neg ^ b_neg;
                    r_neg  <= a_neg;
                    // Fast-path results come from the raw operands
                    if (div0)     RESULT <= in_rem ? DIVIDEND : '1;
                    else if (ovf) RESULT <= in_rem ? '0 : MIN_NEG;
                end
                S_CALC: begin
                    rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                end
                S_FIX:   RESULT <= op_rem ? r_fix : q_fix;
                default: ;
            endcase
        end
    end

    // Status outputs; STALL drops in DONE so the instruction advances with RESULT
    always_comb begin
        BUSY  = (state == S_CALC) || (state == S_FIX);
        DONE  = (state == S_DONE);
        STALL = ((state == S_IDLE) && START && !FLUSH) || BUSY;
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: table of operations plus hand-written
// back-to-back, flush-abort and reset-abort sequences.
module tb_div_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [2:0]  FUNCT3;
    logic [31:0] DIVIDEND, DIVISOR;
    logic        STALL, BUSY, DONE;
    logic [31:0] RESULT;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
        .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .FLUSH(FLUSH),
        .STALL(STALL), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op with a single-cycle START and follow it cycle by cycle
    task automatic run_vec(input vec_t v);
        int          bad;
        logic        done_seen;
        logic        exp_busy;
        logic [31:0] res;
        bad = 0; done_seen = 1'b0; res = '0;
        @(negedge CLK);
        FUNCT3 = v.f; DIVIDEND = v.a; DIVISOR = v.b; START = 1'b1;
        #1;
        if (STALL !== 1'b1 || BUSY !== 1'b0) bad++;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int c = 1; c <= v.lat + 1; c++) begin
            @(negedge CLK);
            exp_busy = (v.lat > 1) && (c <= v.lat - 1);
            if (STALL !== exp_busy || BUSY !== exp_busy) bad++;
            if (c == v.lat) begin
                done_seen = DONE;
                res = RESULT;
            end else if (DONE !== 1'b0) bad++;
        end
        chk({v.name, "_profile"}, bad, 0);
        chk({v.name, "_done"}, {31'b0, done_seen}, 1);
        chk({v.name, "_result"}, res, v.exp);
    endtask

    // Start an op and return just after the accepting edge (in cycle 1)
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        FUNCT3 = f; DIVIDEND = a; DIVISOR = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    // Abort a DIVU in cycle 10 with either FLUSH or RESET, check the aftermath
    task automatic abort_seq(input bit use_reset, input logic [31:0] exp_res);
        int bad;
        bad = 0;
        start_op(3'b101, 32'd1000, 32'd3);
        for (int c = 1; c <= 10; c++) @(negedge CLK);
        if (use_reset) RESET = 1'b0; else FLUSH = 1'b1;
        @(negedge CLK);
        chk(use_reset ? "rst_abort_stall" : "flush_stall", {31'b0, STALL}, 0);
        chk(use_reset ? "rst_abort_busy"  : "flush_busy",  {31'b0, BUSY},  0);
        chk(use_reset ? "rst_abort_done"  : "flush_done",  {31'b0, DONE},  0);
        chk(use_reset ? "rst_abort_result": "flush_result", RESULT, exp_res);
        RESET = 1'b1; FLUSH = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        chk(use_reset ? "rst_abort_quiet" : "flush_quiet", bad, 0);
    endtask

    initial begin
        vecs[0]  = '{"divu_100_7",    3'b101, 32'd100,        32'd7,          32'd14,         34};
        vecs[1]  = '{"rem_m7_2",      3'b110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34};
        vecs[2]  = '{"div_m7_2",      3'b100, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   34};
        vecs[3]  = '{"divu_5_0",      3'b101, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
        vecs[4]  = '{"remu_5_0",      3'b111, 32'd5,          32'd0,          32'd5,          1};
        vecs[5]  = '{"rem_m5_0",      3'b110, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1};
        vecs[6]  = '{"div_ovf",       3'b100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
        vecs[7]  = '{"rem_ovf",       3'b110, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
        vecs[8]  = '{"remu_100_7",    3'b111, 32'd100,        32'd7,          32'd2,          34};
        vecs[9]  = '{"div_min_2",     3'b100, 32'h80000000,   32'd2,          32'hC0000000,   34};
        vecs[10] = '{"rem_7_m2",      3'b110, 32'd7,          32'hFFFFFFFE,   32'd1,          34};
        vecs[11] = '{"div_7_m2",      3'b100, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   34};
        vecs[12] = '{"divu_max_1",    3'b101, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   34};
        vecs[13] = '{"f000_as_divu",  3'b000, 32'd100,        32'd7,          32'd14,         34};
        vecs[14] = '{"div_m5_0",      3'b100, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1};
        vecs[15] = '{"remu_max_m2",   3'b111, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          34};
        vecs[16] = '{"divu_min_m1",   3'b101, 32'h80000000,   32'hFFFFFFFF,   32'd0,          34};
        vecs[17] = '{"rem_m100_7",    3'b110, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   34};

        RESET = 1'b0; START = 1'b0; FLUSH = 1'b0;
        FUNCT3 = 3'b000; DIVIDEND = '0; DIVISOR = '0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        chk("reset_result", RESULT, 0);
        chk("reset_done",   {31'b0, DONE},  0);
        chk("reset_busy",   {31'b0, BUSY},  0);
        chk("reset_stall",  {31'b0, STALL}, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: START held through DONE; the second op is taken in the next IDLE
        @(negedge CLK);
        FUNCT3 = 3'b101; DIVIDEND = 32'd5; DIVISOR = 32'd0; START = 1'b1;
        @(negedge CLK);
        chk("b2b_first_done",   {31'b0, DONE}, 1);
        chk("b2b_first_result", RESULT, 32'hFFFFFFFF);
        FUNCT3 = 3'b111;
        @(negedge CLK);
        chk("b2b_idle_done",  {31'b0, DONE},  0);
        chk("b2b_idle_stall", {31'b0, STALL}, 1);
        @(negedge CLK);
        START = 1'b0;
        chk("b2b_second_done",   {31'b0, DONE}, 1);
        chk("b2b_second_result", RESULT, 32'd5);

        // Flush abort keeps the previous RESULT, then a normal op follows
        run_vec(vecs[8]);
        abort_seq(1'b0, 32'd2);
        run_vec(vecs[0]);

        // Reset abort clears RESULT, then a normal op follows
        abort_seq(1'b1, 32'd0);
        run_vec(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Iterative divide sequencer for the EX stage of the RV32IM pipeline; executes DIV, DIVU, REM and REMU.
- Uses a one-bit-per-cycle restoring algorithm over a shared subtract/shift datapath.
- Raises a pipeline stall while computing, then returns the result with a one-cycle done pulse.
- Divide-by-zero and signed overflow bypass the iteration via a fast path.

Parameters:
- WIDTH, 32, operand/result width; the RV32 datapath is fixed at 32.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-low reset.
- START  input  1  request from EX stage; only sampled in IDLE.
- FUNCT3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; other codes are treated as DIVU.
- DIVIDEND  input  WIDTH  rs1 value, sampled with START.
- DIVISOR  input  WIDTH  rs2 value, sampled with START.
- FLUSH  input  1  branch/jump flush; aborts any operation in flight.
- STALL  output  1  freezes PC, IF/ID and ID/EX.
- BUSY  output  1  high in CALC or FIX.
- DONE  output  1  one-cycle pulse; RESULT is valid this cycle.
- RESULT  output  WIDTH  quotient or remainder; held until the next accepted START.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (RESET=0 at an edge): state=IDLE, counter=0, all internal registers=0, RESULT=0, DONE=0, BUSY=0. Reset wins over FLUSH and START, including mid-operation.
- IDLE, START=1, FLUSH=0: latch FUNCT3 and the operands.
  - Signed ops: store the magnitudes of both operands; record quotient sign = sign(dividend) XOR sign(divisor); record remainder sign = sign(dividend).
- Fast path, decided from the raw operands in IDLE; go directly to DONE.
  - DIVISOR=0: quotient=0xFFFFFFFF, remainder=DIVIDEND, for both signed and unsigned ops.
  - DIV/REM with DIVIDEND=0x80000000 and DIVISOR=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Otherwise go to CALC with counter=0 and the partial remainder cleared.
- CALC, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem=trial and quo LSB=1.
  - After the iteration with counter=WIDTH-1, go to FIX; exactly WIDTH CALC cycles.
- FIX: negate quo or rem where the recorded sign is 1 (signed ops only). Select quo for DIV/DIVU, rem for REM/REMU, into RESULT. Go to DONE.
- DONE: DONE=1 for exactly one cycle, then go to IDLE. START is ignored in DONE.
- Latency, counted from the START-accepting edge at cycle 0:
  - Normal ops: DONE is high in cycle WIDTH+2 (34).
  - Fast path: DONE is high in cycle 1.
- STALL is combinational: (state==IDLE && START && !FLUSH) || state==CALC || state==FIX. It is low in DONE so the instruction advances with RESULT.
- Back-to-back ops: if START stays high through DONE for the next instruction, it is accepted in the following IDLE cycle.
- FLUSH=1 in any state:
  - Next state is IDLE; no DONE pulse; RESULT is unchanged.
  - FLUSH overrides START in the same cycle.
- No other wrap-around: the counter stops at WIDTH-1.

Test Plan:
- DIVU, DIVIDEND=100, DIVISOR=7, START for 1 cycle -> STALL high for cycles 0-33; BUSY high for cycles 1-33; DONE pulses in cycle 34 with RESULT=14.
- REM, DIVIDEND=0xFFFFFFF9 (-7), DIVISOR=2 -> RESULT=0xFFFFFFFF (-1) after 34 cycles.
- DIV, DIVIDEND=0xFFFFFFF9 (-7), DIVISOR=2 -> RESULT=0xFFFFFFFD (-3) after 34 cycles.
- Divide by zero:
  - DIVU 5/0 -> DONE in cycle 1, RESULT=0xFFFFFFFF.
  - REMU 5/0 -> RESULT=5.
  - REM 0xFFFFFFFB/0 -> RESULT=0xFFFFFFFB.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> DONE in cycle 1, RESULT=0x80000000. REM with the same operands -> RESULT=0.
- Abort cases:
  - FLUSH=1 in cycle 10 of a DIVU -> IDLE in cycle 11; STALL and BUSY low; no DONE; RESULT keeps its prior value.
  - Repeat with RESET=0 in cycle 10 -> RESULT=0 and all outputs at reset values.
  - Next START accepted normally after either abort.
